// File: rtl/data_ram_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_ram_ctrl_pkg : drain-state encoding, write-entry record, lookup helper |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package data_ram_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;

    typedef struct packed {
        logic [19:0] addr;
        logic [15:0] data;
        logic        word;
    } wr_entry_t;

    function automatic logic [19:0] addr_mask(input int aw);
        return 20'((64'd1 << aw) - 64'd1);
    endfunction

    // Returns {hit, byte} for byte address a (already masked) against one entry.
    function automatic logic [8:0] entry_lookup(input wr_entry_t e,
                                                input logic [19:0] a,
                                                input logic [19:0] mask);
        logic [19:0] lo;
        logic [19:0] hi;
        lo = e.addr & mask;
        hi = (e.addr + 20'd1) & mask;
        if (lo == a)
            return {1'b1, e.data[7:0]};
        if (e.word && (hi == a))
            return {1'b1, e.data[15:8]};
        return 9'h000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_ram_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_ram_ctrl_if : read/write request bus and write-buffer status          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface data_ram_ctrl_if;
    logic        ram_rd_en;
    logic        ram_rd_we;
    logic [19:0] ram_rd_addr;
    logic [15:0] ram_rd_data;
    logic        ram_wr_en;
    logic        ram_wr_we;
    logic [19:0] ram_wr_addr;
    logic [15:0] ram_wr_data;
    logic        wb_empty;
    logic        wb_full;
    logic        wb_overflow;

    modport master (
        output ram_rd_en, ram_rd_we, ram_rd_addr,
        output ram_wr_en, ram_wr_we, ram_wr_addr, ram_wr_data,
        input  ram_rd_data, wb_empty, wb_full, wb_overflow
    );

    modport slave (
        input  ram_rd_en, ram_rd_we, ram_rd_addr,
        input  ram_wr_en, ram_wr_we, ram_wr_addr, ram_wr_data,
        output ram_rd_data, wb_empty, wb_full, wb_overflow
    );
endinterface
`default_nettype wire

// File: rtl/data_ram_ctrl_wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_fifo : posted-write circular buffer with newest-first byte lookup       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module wb_fifo
    import data_ram_ctrl_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  wr_entry_t               entry_i,
    input  logic                    pop_i,
    output wr_entry_t               head_o,
    output logic [$clog2(DEPTH):0]  count_o,
    input  logic [1:0][19:0]        lk_addr_i,
    output logic [1:0]              lk_hit_o,
    output logic [1:0][7:0]         lk_data_o
);
    localparam int          PTR_W     = $clog2(DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [19:0] ADDR_MASK = addr_mask(ADDR_W);

    wr_entry_t        buf_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] idx;
    logic [8:0]       res;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i)
            buf_q[wr_ptr_q] <= entry_i;
    end

    assign head_o  = buf_q[rd_ptr_q];
    assign count_o = count_q;

    // Walk oldest to newest so the newest matching entry overwrites older hits.
    always_comb begin
        lk_hit_o  = '0;
        lk_data_o = '0;
        idx       = '0;
        res       = '0;
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (CNT_W'(k) < count_q) begin
                    idx = rd_ptr_q + PTR_W'(k);
                    res = entry_lookup(buf_q[idx], lk_addr_i[g], ADDR_MASK);
                    if (res[8]) begin
                        lk_hit_o[g]  = 1'b1;
                        lk_data_o[g] = res[7:0];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_ram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_ram_ctrl : byte RAM with posted-write buffer, drain FSM, forwarding   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module data_ram_ctrl
    import data_ram_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int WB_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    data_ram_ctrl_if.slave bus
);
    localparam int               CNT_W     = $clog2(WB_DEPTH) + 1;
    localparam logic [19:0]      ADDR_MASK = addr_mask(ADDR_W);
    localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(WB_DEPTH);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count;
    wr_entry_t        head, in_entry;
    logic             push, pop;
    logic [1:0][19:0] rd_a;
    logic [1:0]       fwd_hit;
    logic [1:0][7:0]  fwd_data;
    logic [1:0][7:0]  rd_byte;
    logic [8:0]       inc;
    logic             mem_we;
    logic [19:0]      waddr20;
    logic [7:0]       mem_wdata;
    logic [7:0]       mem_q [2**ADDR_W];
    logic             unused_bits;

    assign in_entry = '{addr: bus.ram_wr_addr & ADDR_MASK,
                        data: bus.ram_wr_data,
                        word: bus.ram_wr_we};

    assign pop  = rst && (count != '0) &&
                  (((state_q == ST_LO) && !head.word) || (state_q == ST_HI));
    // A completing pop frees a slot in the same cycle, so a full buffer can still accept.
    assign push = rst && bus.ram_wr_en && ((count < C_DEPTH) || pop);

    wb_fifo #(
        .DEPTH  (WB_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_wb_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .entry_i   (in_entry),
        .pop_i     (pop),
        .head_o    (head),
        .count_o   (count),
        .lk_addr_i (rd_a),
        .lk_hit_o  (fwd_hit),
        .lk_data_o (fwd_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (push || (count != '0)) state_d = ST_LO;
            ST_LO: begin
                if (head.word)
                    state_d = ST_HI;
                else if ((count <= C_ONE) && !push)
                    state_d = ST_IDLE;
            end
            ST_HI: state_d = ((count <= C_ONE) && !push) ? ST_IDLE : ST_LO;
            default: state_d = ST_IDLE;
        endcase
        ovf_d = ovf_q | (bus.ram_wr_en & ~push);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    assign mem_we    = rst && (count != '0) && ((state_q == ST_LO) || (state_q == ST_HI));
    assign waddr20   = head.addr + 20'(state_q == ST_HI);
    assign mem_wdata = (state_q == ST_HI) ? head.data[15:8] : head.data[7:0];

    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[waddr20[ADDR_W-1:0]] <= mem_wdata;
    end

    assign rd_a[0] = bus.ram_rd_addr & ADDR_MASK;
    assign rd_a[1] = (bus.ram_rd_addr + 20'd1) & ADDR_MASK;

    // Each byte picks incoming write, then buffered entries, then the array.
    always_comb begin
        rd_byte = '0;
        inc     = '0;
        for (int b = 0; b < 2; b++) begin
            inc = entry_lookup(in_entry, rd_a[b], ADDR_MASK);
            if (push && inc[8])
                rd_byte[b] = inc[7:0];
            else if (rst && fwd_hit[b])
                rd_byte[b] = fwd_data[b];
            else
                rd_byte[b] = mem_q[rd_a[b][ADDR_W-1:0]];
        end
    end

    assign bus.ram_rd_data = !bus.ram_rd_en ? 16'h0000 :
                             bus.ram_rd_we  ? {rd_byte[1], rd_byte[0]} :
                                              {8'h00, rd_byte[0]};

    assign bus.wb_empty    = !rst || (count == '0);
    assign bus.wb_full     = rst && (count == C_DEPTH);
    assign bus.wb_overflow = rst && ovf_q;

    assign unused_bits = ^(waddr20 & ~ADDR_MASK);

endmodule
`default_nettype wire
